// File: rtl/cmul_seq.sv
// Sequential complex multiplier: one shared WxW multiplier and one add/sub over four steps (optional CMUL_SEQ_SAT_EN clamps outputs).
// Result valid 5 cycles after the accepting cycle, initiation interval 6; results hold while out_ready is low, inputs refused while busy.
module cmul_seq #(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [2*W:0] p_re,
    output logic signed [2*W:0] p_im,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M0   = 3'd1,
        S_M1   = 3'd2,
        S_M2   = 3'd3,
        S_M3   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state_q;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   busy_q;
    logic   accept;

    logic signed [W-1:0]   are_q, aim_q, bre_q, bim_q;
    logic signed [2*W:0]   acc_re_q, acc_im_q;
    logic signed [W-1:0]   mul_a, mul_b;
    logic signed [2*W-1:0] mul_a_x, mul_b_x, prod;
    logic signed [2*W:0]   prod_x, addend, sum_d;
    logic                  sub_sel;

    assign accept = (state_q == S_IDLE) && in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state_q    <= S_M0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_M0: state_q <= S_M1;
                S_M1: state_q <= S_M2;
                S_M2: state_q <= S_M3;
                S_M3: begin
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Shared multiplier operand select: re*re, im*im, re*im, im*re
    always_comb begin
        mul_a = are_q;
        mul_b = bre_q;
        case (state_q)
            S_M1: begin
                mul_a = aim_q;
                mul_b = bim_q;
            end
            S_M2: begin
                mul_a = are_q;
                mul_b = bim_q;
            end
            S_M3: begin
                mul_a = aim_q;
                mul_b = bre_q;
            end
            default: begin
                mul_a = are_q;
                mul_b = bre_q;
            end
        endcase
    end

    assign mul_a_x = {{W{mul_a[W-1]}}, mul_a};
    assign mul_b_x = {{W{mul_b[W-1]}}, mul_b};
    assign prod    = mul_a_x * mul_b_x;
    assign prod_x  = {prod[2*W-1], prod};

    // M0/M2 load a fresh product (0 + p); M1 subtracts, M3 adds
    always_comb begin
        addend = '0;
        if (state_q == S_M1)
            addend = acc_re_q;
        else if (state_q == S_M3)
            addend = acc_im_q;
    end

    assign sub_sel = (state_q == S_M1);
    assign sum_d   = sub_sel ? (addend - prod_x) : (addend + prod_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            are_q    <= '0;
            aim_q    <= '0;
            bre_q    <= '0;
            bim_q    <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            if (accept) begin
                are_q <= a_re;
                aim_q <= a_im;
                bre_q <= b_re;
                bim_q <= b_im;
            end
            if (state_q == S_M0 || state_q == S_M1)
                acc_re_q <= sum_d;
            if (state_q == S_M2 || state_q == S_M3)
                acc_im_q <= sum_d;
        end
    end

`ifdef CMUL_SEQ_SAT_EN
    localparam logic signed [2*W:0] SAT_MAX = {2'b00, {(2*W-1){1'b1}}};
    localparam logic signed [2*W:0] SAT_MIN = {2'b11, {(2*W-1){1'b0}}};

    function automatic logic signed [2*W:0] sat(input logic signed [2*W:0] v);
        if (v > SAT_MAX)
            return SAT_MAX;
        else if (v < SAT_MIN)
            return SAT_MIN;
        return v;
    endfunction

    assign p_re = sat(acc_re_q);
    assign p_im = sat(acc_im_q);
`else
    assign p_re = acc_re_q;
    assign p_im = acc_im_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
